riio_ibias_ctrl: RTL and testbench

Digital power-up sequencer and controller that drives the control side of the EG1D80V IO bias/bandgap cell.
- Drives EN_IBIAS/EN_VBIAS, pulses BG_STARTUP and applies trim codes.
- Waits for the bandgap to settle, then qualifies the cell's asynchronous BG_VALID and reports READY or FAULT.
- Sits in the always-on IO control domain between the pad-ring configuration registers and the bias cell.

---
 rtl/riio_ibias_ctrl_pkg.sv | 26 ++
 rtl/riio_sync2.sv | 27 ++
 rtl/riio_ibias_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_riio_ibias_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riio_ibias_ctrl_pkg.sv
// Shared types and constants for the EG1D80V IO bias/bandgap control block.
// The state set, trim widths and default sequencing times all live here.
package riio_ibias_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_STARTUP = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_CHECK   = 3'd3,
      ST_READY   = 3'd4,
      ST_FAULT   = 3'd5
   } state_e;

   localparam int unsigned IBIAS_TRIM_W = 5;
   localparam int unsigned VBIAS_TRIM_W = 4;

   localparam int unsigned DEF_STARTUP_CYC = 16;
   localparam int unsigned DEF_SETTLE_CYC  = 256;
   localparam int unsigned DEF_TIMEOUT_CYC = 1024;
   localparam int unsigned DEF_CNT_W       = 12;

   function automatic logic f_is_busy(input state_e s);
      return (s == ST_STARTUP) || (s == ST_SETTLE) || (s == ST_CHECK);
   endfunction

endpackage

// File: rtl/riio_sync2.sv
// Generic two-flop synchronizer with synchronous active-low reset.
module riio_sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // two-stage resynchronisation of an asynchronous input
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_meta <= {WIDTH{1'b0}};
         r_sync <= {WIDTH{1'b0}};
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/riio_ibias_ctrl.sv
// Power-up sequencer for the IO bias/bandgap cell: enables, startup pulse,
// trim application, settle wait and qualification of the bandgap valid flag.
module riio_ibias_ctrl
   import riio_ibias_ctrl_pkg::*;
#(
   parameter int unsigned STARTUP_CYC = DEF_STARTUP_CYC,
   parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic                    CLK_I,
   input  logic                    RSTN_I,
   input  logic                    REQ_IBIAS_I,
   input  logic                    REQ_VBIAS_I,
   input  logic [IBIAS_TRIM_W-1:0] TRIM_IBIAS_CFG_I,
   input  logic [VBIAS_TRIM_W-1:0] TRIM_VBIAS_CFG_I,
   input  logic                    TRIM_UPD_I,
   input  logic                    CLR_FAULT_I,
   input  logic                    BG_VALID_I,
   output logic                    EN_IBIAS_O,
   output logic                    EN_VBIAS_O,
   output logic                    BG_STARTUP_O,
   output logic [IBIAS_TRIM_W-1:0] TRIM_IBIAS_O,
   output logic [VBIAS_TRIM_W-1:0] TRIM_VBIAS_O,
   output logic                    READY_O,
   output logic                    BUSY_O,
   output logic                    FAULT_O
);

   localparam logic [CNT_W-1:0] L_CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] L_CNT_ONE    = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] L_STARTUP_LD = CNT_W'(STARTUP_CYC - 32'd1);
   localparam logic [CNT_W-1:0] L_SETTLE_LD  = CNT_W'(SETTLE_CYC - 32'd1);
   localparam logic [CNT_W-1:0] L_TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 32'd1);

   state_e                  r_state;
   state_e                  w_state_nxt;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        w_cnt_nxt;
   logic                    r_en_ibias;
   logic                    r_en_vbias;
   logic                    w_en_ibias_nxt;
   logic                    w_en_vbias_nxt;
   logic [IBIAS_TRIM_W-1:0] r_trim_ibias;
   logic [VBIAS_TRIM_W-1:0] r_trim_vbias;
   logic [IBIAS_TRIM_W-1:0] w_trim_ibias_nxt;
   logic [VBIAS_TRIM_W-1:0] w_trim_vbias_nxt;
   logic                    r_bg_startup;
   logic                    r_ready;
   logic                    r_busy;
   logic                    r_fault;
   logic                    w_vsync;
   logic                    w_req;
   logic                    w_cnt_zero;
   logic                    w_abort;
   logic                    w_en_diff;

   riio_sync2 #(
      .WIDTH (1)
   ) u_vsync (
      .i_clk   (CLK_I),
      .i_rst_n (RSTN_I),
      .i_d     (BG_VALID_I),
      .o_q     (w_vsync)
   );

   assign w_req      = REQ_IBIAS_I | REQ_VBIAS_I;
   assign w_cnt_zero = (r_cnt == L_CNT_ZERO);
   assign w_en_diff  = (REQ_IBIAS_I != r_en_ibias) || (REQ_VBIAS_I != r_en_vbias);
   // FAULT is deliberately excluded: only CLR_FAULT_I leaves it
   assign w_abort    = !w_req && (f_is_busy(r_state) || (r_state == ST_READY));

   // next-state, counter, enable and trim decode
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = w_cnt_zero ? L_CNT_ZERO : (r_cnt - L_CNT_ONE);
      w_en_ibias_nxt   = r_en_ibias;
      w_en_vbias_nxt   = r_en_vbias;
      w_trim_ibias_nxt = r_trim_ibias;
      w_trim_vbias_nxt = r_trim_vbias;
      if (w_abort) begin
         w_state_nxt    = ST_OFF;
         w_cnt_nxt      = L_CNT_ZERO;
         w_en_ibias_nxt = 1'b0;
         w_en_vbias_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_OFF: begin
               if (w_req) begin
                  w_state_nxt      = ST_STARTUP;
                  w_cnt_nxt        = L_STARTUP_LD;
                  w_en_ibias_nxt   = REQ_IBIAS_I;
                  w_en_vbias_nxt   = REQ_VBIAS_I;
                  w_trim_ibias_nxt = TRIM_IBIAS_CFG_I;
                  w_trim_vbias_nxt = TRIM_VBIAS_CFG_I;
               end else begin
                  w_cnt_nxt      = L_CNT_ZERO;
                  w_en_ibias_nxt = 1'b0;
                  w_en_vbias_nxt = 1'b0;
               end
            end
            ST_STARTUP: begin
               if (w_cnt_zero) begin
                  w_state_nxt = ST_SETTLE;
                  w_cnt_nxt   = L_SETTLE_LD;
               end else begin
                  w_state_nxt = ST_STARTUP;
               end
            end
            ST_SETTLE: begin
               if (w_cnt_zero) begin
                  w_state_nxt = ST_CHECK;
                  w_cnt_nxt   = L_TIMEOUT_LD;
               end else begin
                  w_state_nxt = ST_SETTLE;
               end
            end
            ST_CHECK: begin
               // a valid seen on the last timeout cycle still qualifies
               if (w_vsync) begin
                  w_state_nxt = ST_READY;
                  w_cnt_nxt   = L_CNT_ZERO;
               end else if (w_cnt_zero) begin
                  w_state_nxt    = ST_FAULT;
                  w_en_ibias_nxt = 1'b0;
                  w_en_vbias_nxt = 1'b0;
               end else begin
                  w_state_nxt = ST_CHECK;
               end
            end
            ST_READY: begin
               if (!w_vsync) begin
                  w_state_nxt    = ST_FAULT;
                  w_cnt_nxt      = L_CNT_ZERO;
                  w_en_ibias_nxt = 1'b0;
                  w_en_vbias_nxt = 1'b0;
               end else if (TRIM_UPD_I) begin
                  w_state_nxt      = ST_SETTLE;
                  w_cnt_nxt        = L_SETTLE_LD;
                  w_trim_ibias_nxt = TRIM_IBIAS_CFG_I;
                  w_trim_vbias_nxt = TRIM_VBIAS_CFG_I;
               end else if (w_en_diff) begin
                  w_state_nxt    = ST_SETTLE;
                  w_cnt_nxt      = L_SETTLE_LD;
                  w_en_ibias_nxt = REQ_IBIAS_I;
                  w_en_vbias_nxt = REQ_VBIAS_I;
               end else begin
                  w_state_nxt = ST_READY;
                  w_cnt_nxt   = L_CNT_ZERO;
               end
            end
            ST_FAULT: begin
               w_en_ibias_nxt = 1'b0;
               w_en_vbias_nxt = 1'b0;
               w_cnt_nxt      = L_CNT_ZERO;
               if (CLR_FAULT_I) begin
                  w_state_nxt = ST_OFF;
               end else begin
                  w_state_nxt = ST_FAULT;
               end
            end
            default: begin
               w_state_nxt    = ST_OFF;
               w_cnt_nxt      = L_CNT_ZERO;
               w_en_ibias_nxt = 1'b0;
               w_en_vbias_nxt = 1'b0;
            end
         endcase
      end
   end

   // state, counter and latched enable/trim registers
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         r_state      <= ST_OFF;
         r_cnt        <= L_CNT_ZERO;
         r_en_ibias   <= 1'b0;
         r_en_vbias   <= 1'b0;
         r_trim_ibias <= {IBIAS_TRIM_W{1'b0}};
         r_trim_vbias <= {VBIAS_TRIM_W{1'b0}};
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_en_ibias   <= w_en_ibias_nxt;
         r_en_vbias   <= w_en_vbias_nxt;
         r_trim_ibias <= w_trim_ibias_nxt;
         r_trim_vbias <= w_trim_vbias_nxt;
      end
   end

   // status flags registered from the next state so they align with it
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         r_bg_startup <= 1'b0;
         r_busy       <= 1'b0;
         r_ready      <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         r_bg_startup <= (w_state_nxt == ST_STARTUP);
         r_busy       <= f_is_busy(w_state_nxt);
         r_ready      <= (w_state_nxt == ST_READY);
         r_fault      <= (w_state_nxt == ST_FAULT);
      end
   end

   assign EN_IBIAS_O   = r_en_ibias;
   assign EN_VBIAS_O   = r_en_vbias;
   assign BG_STARTUP_O = r_bg_startup;
   assign TRIM_IBIAS_O = r_trim_ibias;
   assign TRIM_VBIAS_O = r_trim_vbias;
   assign READY_O      = r_ready;
   assign BUSY_O       = r_busy;
   assign FAULT_O      = r_fault;

endmodule

// File: tb/tb_riio_ibias_ctrl.sv
// Bench for riio_ibias_ctrl: directed sequencing scenarios followed by random
// traffic, every cycle compared against a phase/time-left reference model.
module tb_riio_ibias_ctrl;

   localparam int STARTUP_CYC = 4;
   localparam int SETTLE_CYC  = 8;
   localparam int TIMEOUT_CYC = 16;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       req_i = 1'b0;
   logic       req_v = 1'b0;
   logic [4:0] tcfg_i = 5'h00;
   logic [3:0] tcfg_v = 4'h0;
   logic       upd = 1'b0;
   logic       clr = 1'b0;
   logic       bg = 1'b0;

   logic       en_i_o, en_v_o, start_o, ready_o, busy_o, fault_o;
   logic [4:0] tr_i_o;
   logic [3:0] tr_v_o;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // reference model: named phase, cycles left in it, and a valid delay line
   string m_phase = "IDLE";
   int    m_left  = 0;
   int    m_en_i = 0, m_en_v = 0, m_tr_i = 0, m_tr_v = 0;
   bit    m_vq[$] = '{1'b0, 1'b0};

   riio_ibias_ctrl #(
      .STARTUP_CYC (STARTUP_CYC),
      .SETTLE_CYC  (SETTLE_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CNT_W       (12)
   ) dut (
      .CLK_I            (clk),
      .RSTN_I           (rstn),
      .REQ_IBIAS_I      (req_i),
      .REQ_VBIAS_I      (req_v),
      .TRIM_IBIAS_CFG_I (tcfg_i),
      .TRIM_VBIAS_CFG_I (tcfg_v),
      .TRIM_UPD_I       (upd),
      .CLR_FAULT_I      (clr),
      .BG_VALID_I       (bg),
      .EN_IBIAS_O       (en_i_o),
      .EN_VBIAS_O       (en_v_o),
      .BG_STARTUP_O     (start_o),
      .TRIM_IBIAS_O     (tr_i_o),
      .TRIM_VBIAS_O     (tr_v_o),
      .READY_O          (ready_o),
      .BUSY_O           (busy_o),
      .FAULT_O          (fault_o)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic m_enter(input string ph, input int len);
      m_phase = ph;
      m_left  = len;
   endtask

   task automatic m_step();
      bit vs;
      bit rq;
      if (!rstn) begin
         m_phase = "IDLE"; m_left = 0;
         m_en_i = 0; m_en_v = 0; m_tr_i = 0; m_tr_v = 0;
         m_vq = '{1'b0, 1'b0};
      end else begin
         vs = m_vq[0];
         void'(m_vq.pop_front());
         m_vq.push_back(bg);
         rq = req_i | req_v;
         if (!rq && m_phase != "IDLE" && m_phase != "BAD") begin
            m_phase = "IDLE"; m_en_i = 0; m_en_v = 0;
         end else if (m_phase == "IDLE") begin
            if (rq) begin
               m_en_i = int'(req_i); m_en_v = int'(req_v);
               m_tr_i = int'(tcfg_i); m_tr_v = int'(tcfg_v);
               m_enter("PULSE", STARTUP_CYC);
            end
         end else if (m_phase == "PULSE") begin
            if (m_left == 1) m_enter("SETTLE", SETTLE_CYC); else m_left--;
         end else if (m_phase == "SETTLE") begin
            if (m_left == 1) m_enter("CHECK", TIMEOUT_CYC); else m_left--;
         end else if (m_phase == "CHECK") begin
            if (vs) m_enter("GOOD", 0);
            else if (m_left == 1) begin m_enter("BAD", 0); m_en_i = 0; m_en_v = 0; end
            else m_left--;
         end else if (m_phase == "GOOD") begin
            if (!vs) begin m_enter("BAD", 0); m_en_i = 0; m_en_v = 0; end
            else if (upd) begin
               m_tr_i = int'(tcfg_i); m_tr_v = int'(tcfg_v);
               m_enter("SETTLE", SETTLE_CYC);
            end else if (m_en_i != int'(req_i) || m_en_v != int'(req_v)) begin
               m_en_i = int'(req_i); m_en_v = int'(req_v);
               m_enter("SETTLE", SETTLE_CYC);
            end
         end else begin
            if (clr) m_phase = "IDLE";
         end
      end
   endtask

   // one clock: advance the model on the edge, compare all outputs just after
   task automatic cycle();
      int busy_exp;
      @(posedge clk);
      m_step();
      #1;
      cyc++;
      busy_exp = (m_phase == "PULSE" || m_phase == "SETTLE" || m_phase == "CHECK") ? 1 : 0;
      chk_eq("en_ibias",   int'(en_i_o),  m_en_i);
      chk_eq("en_vbias",   int'(en_v_o),  m_en_v);
      chk_eq("trim_ibias", int'(tr_i_o),  m_tr_i);
      chk_eq("trim_vbias", int'(tr_v_o),  m_tr_v);
      chk_eq("bg_startup", int'(start_o), (m_phase == "PULSE") ? 1 : 0);
      chk_eq("busy",       int'(busy_o),  busy_exp);
      chk_eq("ready",      int'(ready_o), (m_phase == "GOOD") ? 1 : 0);
      chk_eq("fault",      int'(fault_o), (m_phase == "BAD") ? 1 : 0);
   endtask

   initial begin
      // reset with valid already high so the synchronizer is primed on release
      bg = 1'b1;
      repeat (3) cycle();
      chk_eq("rst_trim_i", int'(tr_i_o), 0);
      chk_eq("rst_busy", int'(busy_o), 0);
      rstn = 1'b1;

      // nominal power-up
      req_i = 1'b1; tcfg_i = 5'h13; tcfg_v = 4'h5;
      for (int n = 1; n <= 14; n++) begin
         cycle();
         if (n == 1) begin
            chk_eq("nom_en_c1", int'(en_i_o), 1);
            chk_eq("nom_start_c1", int'(start_o), 1);
            chk_eq("nom_trim_c1", int'(tr_i_o), 'h13);
         end
         if (n == 4) chk_eq("nom_start_c4", int'(start_o), 1);
         if (n == 5) chk_eq("nom_start_c5", int'(start_o), 0);
         if (n == 13) chk_eq("nom_busy_c13", int'(busy_o), 1);
         if (n == 14) begin
            chk_eq("nom_ready_c14", int'(ready_o), 1);
            chk_eq("nom_busy_c14", int'(busy_o), 0);
         end
      end

      // trim update from READY: no new startup pulse, 8 settle + 1 check
      tcfg_v = 4'hA; upd = 1'b1;
      cycle();
      upd = 1'b0;
      chk_eq("upd_trim_v", int'(tr_v_o), 'hA);
      chk_eq("upd_ready", int'(ready_o), 0);
      for (int n = 1; n <= 9; n++) begin
         cycle();
         chk_eq("upd_no_pulse", int'(start_o), 0);
         chk_eq("upd_ready_n", int'(ready_o), (n == 9) ? 1 : 0);
      end

      // loss of valid while READY
      bg = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         cycle();
         chk_eq("lov_fault", int'(fault_o), (n == 3) ? 1 : 0);
      end
      chk_eq("lov_ready", int'(ready_o), 0);

      // clear with request held: full restart, then timeout with valid low
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      for (int n = 1; n <= 29; n++) begin
         cycle();
         if (n == 1) chk_eq("to_restart_pulse", int'(start_o), 1);
         if (n == 28) chk_eq("to_fault_c28", int'(fault_o), 0);
         if (n == 29) begin
            chk_eq("to_fault_c29", int'(fault_o), 1);
            chk_eq("to_en_c29", int'(en_i_o), 0);
         end
      end

      // restart and abort during SETTLE with a coincident trim update
      bg = 1'b1; clr = 1'b1;
      cycle();
      clr = 1'b0;
      for (int n = 1; n <= 5; n++) cycle();
      chk_eq("ab_in_settle", int'(busy_o), 1);
      req_i = 1'b0; req_v = 1'b0; upd = 1'b1; tcfg_i = 5'h07; tcfg_v = 4'h3;
      cycle();
      upd = 1'b0;
      chk_eq("ab_busy", int'(busy_o), 0);
      chk_eq("ab_en_i", int'(en_i_o), 0);
      chk_eq("ab_trim_i", int'(tr_i_o), 'h13);
      chk_eq("ab_trim_v", int'(tr_v_o), 'hA);

      // reset during STARTUP
      req_v = 1'b1;
      cycle();
      chk_eq("rs_start", int'(start_o), 1);
      chk_eq("rs_trim_v", int'(tr_v_o), 'h3);
      rstn = 1'b0;
      cycle();
      chk_eq("rs_trim_i0", int'(tr_i_o), 0);
      chk_eq("rs_trim_v0", int'(tr_v_o), 0);
      chk_eq("rs_en_v0", int'(en_v_o), 0);
      chk_eq("rs_start0", int'(start_o), 0);
      rstn = 1'b1;

      // random traffic against the model
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(99, 0) < 2) req_i = ~req_i;
         if ($urandom_range(99, 0) < 2) req_v = ~req_v;
         if ($urandom_range(99, 0) < 2) bg = ~bg;
         if ($urandom_range(99, 0) < 40 && !bg) bg = 1'b1;
         upd    = ($urandom_range(99, 0) < 4);
         clr    = ($urandom_range(99, 0) < 8);
         rstn   = ($urandom_range(999, 0) >= 3);
         tcfg_i = 5'($urandom);
         tcfg_v = 4'($urandom);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
